// File: rtl/i2c_pkg.sv
// Shared I2C constants: slave address-receiver FSM encodings and address-byte framing.
package i2c_pkg;

  localparam int unsigned STATE_W   = 3;
  localparam int unsigned ADDR_BITS = 8;
  localparam int unsigned CNT_W     = 4;

  localparam logic [6:0] GENERAL_CALL_ADDR = 7'h00;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ADDR   = 3'd1;
  localparam logic [2:0] ST_ACK    = 3'd2;
  localparam logic [2:0] ST_PASS   = 3'd3;
  localparam logic [2:0] ST_IGNORE = 3'd4;

endpackage

// File: rtl/slave_sync_edge.sv
// Multi-flop synchroniser for one bus line with rise/fall pulses from the last two samples.
module slave_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise_c,
  output logic fall_c
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Reset to the idle (released, high) bus level so reset itself creates no edges on a quiet bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level  = sync_q[SYNC_STAGES-1];
  assign rise_c = level & ~prev_q;
  assign fall_c = ~level & prev_q;

endmodule

// File: rtl/slave_sipo_addr_rx.sv
// I2C slave address-byte receiver: START/STOP detect, 8-bit shift-in, own-address compare, ACK drive.
// Optional build macro SLAVE_GENERAL_CALL_EN also ACKs the general-call address with write.
module slave_sipo_addr_rx
  import i2c_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ADDR_W      = 7
) (
  input  logic              slave_scl_sixt,
  input  logic              slave_rst,
  input  logic              slave_scl_in,
  input  logic              slave_sda_in,
  input  logic [ADDR_W-1:0] slave_own_address,
  output logic              slave_sda_oe,
  output logic [ADDR_W-1:0] slave_rx_address,
  output logic              slave_rd_wr,
  output logic              slave_addr_valid,
  output logic              slave_addr_match,
  output logic              slave_busy
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  slave_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
    .clk    (slave_scl_sixt),
    .rst    (slave_rst),
    .pin    (slave_scl_in),
    .level  (scl_lvl),
    .rise_c (scl_rise),
    .fall_c (scl_fall)
  );

  slave_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
    .clk    (slave_scl_sixt),
    .rst    (slave_rst),
    .pin    (slave_sda_in),
    .level  (sda_lvl),
    .rise_c (sda_rise),
    .fall_c (sda_fall)
  );

  logic [STATE_W-1:0]   state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [ADDR_BITS-1:0] sr, sr_n;
  logic                 pend, pend_n;
  logic [ADDR_W-1:0]    rx_n;
  logic                 rw_n, valid_n, oe_n, match_n, busy_n;

  logic start_c, stop_c, hit_c;

  assign start_c = sda_fall & scl_lvl;
  assign stop_c  = sda_rise & scl_lvl;

  // Address compare uses the byte as it will look after the 8th shift (sr[6:0] + current sda).
`ifdef SLAVE_GENERAL_CALL_EN
  assign hit_c = (sr[ADDR_W-1:0] == slave_own_address) ||
                 ((sr[ADDR_W-1:0] == GENERAL_CALL_ADDR) && !sda_lvl);
`else
  assign hit_c = (sr[ADDR_W-1:0] == slave_own_address);
`endif

  always_ff @(posedge slave_scl_sixt or posedge slave_rst) begin
    if (slave_rst) begin
      state            <= ST_IDLE;
      cnt              <= '0;
      sr               <= '0;
      pend             <= 1'b0;
      slave_rx_address <= '0;
      slave_rd_wr      <= 1'b0;
      slave_addr_valid <= 1'b0;
      slave_sda_oe     <= 1'b0;
      slave_addr_match <= 1'b0;
      slave_busy       <= 1'b0;
    end else begin
      state            <= state_n;
      cnt              <= cnt_n;
      sr               <= sr_n;
      pend             <= pend_n;
      slave_rx_address <= rx_n;
      slave_rd_wr      <= rw_n;
      slave_addr_valid <= valid_n;
      slave_sda_oe     <= oe_n;
      slave_addr_match <= match_n;
      slave_busy       <= busy_n;
    end
  end

  // Bus conditions outrank any SCL edge seen in the same clock.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sr_n    = sr;
    pend_n  = pend;
    rx_n    = slave_rx_address;
    rw_n    = slave_rd_wr;
    valid_n = slave_addr_valid;
    oe_n    = slave_sda_oe;
    match_n = 1'b0;
    busy_n  = slave_busy;

    if (stop_c) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
      valid_n = 1'b0;
      oe_n    = 1'b0;
      busy_n  = 1'b0;
      pend_n  = 1'b0;
    end else if (start_c) begin
      state_n = ST_ADDR;
      cnt_n   = '0;
      sr_n    = '0;
      valid_n = 1'b0;
      oe_n    = 1'b0;
      busy_n  = 1'b1;
      pend_n  = 1'b0;
    end else begin
      case (state)
        ST_ADDR: begin
          if (scl_rise && (cnt < CNT_W'(ADDR_BITS))) begin
            sr_n  = {sr[ADDR_BITS-2:0], sda_lvl};
            cnt_n = cnt + CNT_W'(1);
            if (cnt == CNT_W'(ADDR_BITS - 1)) begin
              rx_n    = sr[ADDR_W-1:0];
              rw_n    = sda_lvl;
              valid_n = 1'b1;
              pend_n  = hit_c;
            end
          end else if (scl_fall && (cnt == CNT_W'(ADDR_BITS))) begin
            if (pend) begin
              state_n = ST_ACK;
              oe_n    = 1'b1;
              match_n = 1'b1;
            end else begin
              state_n = ST_IGNORE;
            end
          end
        end
        ST_ACK: begin
          if (scl_fall) begin
            state_n = ST_PASS;
            oe_n    = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_slave_sipo_addr_rx.sv
// Directed bench for slave_sipo_addr_rx: table of address frames plus multi-cycle corner sequences.
module tb_slave_sipo_addr_rx;
  import i2c_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       sda = 1'b1;
  logic [6:0] own = 7'h50;
  logic       sda_oe, rd_wr, addr_valid, addr_match, busy;
  logic [6:0] rx_address;

  int checks = 0;
  int errors = 0;
  int match_cnt = 0;
  int oe_cnt = 0;

  slave_sipo_addr_rx #(.SYNC_STAGES(2), .ADDR_W(7)) dut (
    .slave_scl_sixt    (clk),
    .slave_rst         (rst),
    .slave_scl_in      (scl),
    .slave_sda_in      (sda),
    .slave_own_address (own),
    .slave_sda_oe      (sda_oe),
    .slave_rx_address  (rx_address),
    .slave_rd_wr       (rd_wr),
    .slave_addr_valid  (addr_valid),
    .slave_addr_match  (addr_match),
    .slave_busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (addr_match) match_cnt <= match_cnt + 1;
    if (sda_oe)     oe_cnt    <= oe_cnt + 1;
  end

  typedef struct {
    logic [7:0] frame;
    logic [6:0] own;
    logic       ack;
    logic [6:0] rx;
    logic       rw;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_start();
    sda = 1'b1; wait_clk(4);
    scl = 1'b1; wait_clk(8);
    sda = 1'b0; wait_clk(8);
    scl = 1'b0; wait_clk(4);
  endtask

  task automatic send_bit(input logic b);
    sda = b;    wait_clk(4);
    scl = 1'b1; wait_clk(8);
    scl = 1'b0; wait_clk(4);
  endtask

  task automatic send_stop();
    sda = 1'b0; wait_clk(4);
    scl = 1'b1; wait_clk(8);
    sda = 1'b1; wait_clk(8);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  // Full addressed frame plus master-released ACK clock; checks outcome and STOP cleanup.
  task automatic run_frame(input string tag, input vec_t v, input logic with_start);
    int m0, o0;
    own = v.own;
    m0 = match_cnt;
    o0 = oe_cnt;
    if (with_start) send_start();
    send_byte(v.frame);
    send_bit(1'b1);
    chk({tag, " match_pulses"}, 32'(match_cnt - m0), v.ack ? 32'd1 : 32'd0);
    chk({tag, " oe_seen"}, 32'(oe_cnt > o0), 32'(v.ack));
    chk({tag, " rx_address"}, 32'(rx_address), 32'(v.rx));
    chk({tag, " rd_wr"}, 32'(rd_wr), 32'(v.rw));
    chk({tag, " addr_valid"}, 32'(addr_valid), 32'd1);
    chk({tag, " busy"}, 32'(busy), 32'd1);
    chk({tag, " sda_oe_after_ack"}, 32'(sda_oe), 32'd0);
    chk({tag, " state"}, 32'(dut.state), v.ack ? 32'(ST_PASS) : 32'(ST_IGNORE));
    send_stop();
    chk({tag, " stop_busy"}, 32'(busy), 32'd0);
    chk({tag, " stop_valid"}, 32'(addr_valid), 32'd0);
    chk({tag, " stop_state"}, 32'(dut.state), 32'(ST_IDLE));
  endtask

  vec_t vecs[6];
  logic gc;

  initial begin
`ifdef SLAVE_GENERAL_CALL_EN
    gc = 1'b1;
`else
    gc = 1'b0;
`endif
    vecs[0] = '{frame: 8'hA0, own: 7'h50, ack: 1'b1, rx: 7'h50, rw: 1'b0};
    vecs[1] = '{frame: 8'hA7, own: 7'h50, ack: 1'b0, rx: 7'h53, rw: 1'b1};
    vecs[2] = '{frame: 8'hA1, own: 7'h50, ack: 1'b1, rx: 7'h50, rw: 1'b1};
    vecs[3] = '{frame: 8'h00, own: 7'h50, ack: gc,   rx: 7'h00, rw: 1'b0};
    vecs[4] = '{frame: 8'h01, own: 7'h50, ack: 1'b0, rx: 7'h00, rw: 1'b1};
    vecs[5] = '{frame: 8'h55, own: 7'h2A, ack: 1'b1, rx: 7'h2A, rw: 1'b1};

    wait_clk(3);
    chk("reset_outputs", 32'({sda_oe, rx_address, rd_wr, addr_valid, addr_match, busy}), 32'd0);
    rst = 1'b0;
    wait_clk(4);
    chk("idle_state", 32'(dut.state), 32'(ST_IDLE));

    for (int i = 0; i < 6; i++) run_frame($sformatf("vec%0d", i), vecs[i], 1'b1);

    // Repeated START after 4 bits restarts the bit count.
    begin
      int m0;
      own = 7'h50;
      m0 = match_cnt;
      send_start();
      send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
      chk("rs_busy_mid", 32'(busy), 32'd1);
      sda = 1'b1; wait_clk(4);
      scl = 1'b1; wait_clk(8);
      sda = 1'b0; wait_clk(8);
      scl = 1'b0; wait_clk(4);
      chk("rs_match_none_yet", 32'(match_cnt - m0), 32'd0);
      run_frame("rs", vecs[2], 1'b0);
    end

    // STOP during the ACK clock high phase drops sda_oe and busy together.
    begin
      int n;
      own = 7'h50;
      send_start();
      send_byte(8'hA0);
      sda = 1'b0; wait_clk(4);
      scl = 1'b1; wait_clk(6);
      chk("stop_ack_oe_before", 32'(sda_oe), 32'd1);
      sda = 1'b1;
      n = 0;
      while (sda_oe && n < 10) begin
        wait_clk(1);
        n++;
      end
      chk("stop_ack_oe_timeout", 32'(sda_oe), 32'd0);
      chk("stop_ack_latency", 32'(n), 32'd3);
      chk("stop_ack_busy", 32'(busy), 32'd0);
      chk("stop_ack_valid", 32'(addr_valid), 32'd0);
      chk("stop_ack_state", 32'(dut.state), 32'(ST_IDLE));
      wait_clk(8);
    end

    // Asynchronous reset mid-address, then a normal frame.
    own = 7'h50;
    send_start();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    chk("rst_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_outputs_now", 32'({sda_oe, rx_address, rd_wr, addr_valid, addr_match, busy}), 32'd0);
    chk("rst_state_now", 32'(dut.state), 32'(ST_IDLE));
    wait_clk(2);
    rst = 1'b0;
    wait_clk(4);
    run_frame("post_rst", vecs[0], 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
